// File: rtl/reg_file_2r1w.sv
// 32-entry integer register file: two combinational read ports, one writeback port,
// and a per-register pending-write scoreboard. Optional macro: WRITE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            sb_set,
  input  logic [4:0]      sb_set_addr,
  input  logic            sb_flush
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic            wr_ok;
  logic            set_ok;

  // x0 and out-of-range addresses never hold state.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  assign wr_ok  = wr_en  && addr_ok(rd_addr);
  assign set_ok = sb_set && addr_ok(sb_set_addr);

  // Issue takes priority over writeback on the same entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sb_next = sb;
    if (sb_flush) begin
      sb_next = '0;
    end else if (wr_ok) begin
      sb_next[rd_addr[AW-1:0]] = 1'b0;
    end
    if (set_ok) begin
      sb_next[sb_set_addr[AW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly because software relies on
      // architectural registers reading zero after reset; this costs a reset on every flop.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      // NOTE: sequential state is always assigned with <= so all flops update together.
      sb <= '0;
    end else begin
      if (wr_ok) begin
        regs[rd_addr[AW-1:0]] <= rd_data;
      end
      sb <= sb_next;
    end
  end

  logic [4:0] rs_addr [2];
  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [XLEN-1:0] data;
    logic            busy;

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (addr_ok(rs_addr[p])) begin
        data = regs[rs_addr[p][AW-1:0]];
        busy = sb[rs_addr[p][AW-1:0]];
      end
`ifdef WRITE_BYPASS_EN
      // Forward writeback data in the same cycle; busy stays only if a new producer issues.
      if (wr_ok && (rs_addr[p] == rd_addr)) begin
        data = rd_data;
        busy = set_ok && (sb_set_addr == rd_addr);
      end
`else
      // Reads see storage only; writeback becomes visible after the edge.
`endif
    end
  end

  assign rs1_data = g_port[0].data;
  assign rs1_busy = g_port[0].busy;
  assign rs2_data = g_port[1].data;
  assign rs2_busy = g_port[1].busy;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed vector table, hand-written corner
// sequences, and randomized traffic against an array-based reference model.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, sb_set_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rs1_busy, rs2_busy, wr_en, sb_set, sb_flush;

  reg_file_2r1w #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural contents and pending bits.
  logic [31:0] m_regs [32];
  logic        m_sb   [32];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef WRITE_BYPASS_EN
    if (!rst && wr_en && rd_addr != 0 && a == rd_addr) return rd_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef WRITE_BYPASS_EN
    if (!rst && wr_en && rd_addr != 0 && a == rd_addr) return sb_set && sb_set_addr == a;
`endif
    return m_sb[a];
  endfunction

  // One rising edge; the model applies the architectural rules to the inputs present.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_sb[i] = 1'b0;
      end
    end else begin
      if (wr_en && rd_addr != 0) m_regs[rd_addr] = rd_data;
      if (sb_flush) begin
        for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
      end else if (wr_en && rd_addr != 0) begin
        m_sb[rd_addr] = 1'b0;
      end
      if (sb_set && sb_set_addr != 0) m_sb[sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_addr = 0; rd_data = 0;
    sb_set = 0; sb_set_addr = 0; sb_flush = 0;
  endtask

  typedef struct {
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        sb_flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] exp_rs1_data;
    logic        exp_rs1_busy;
    logic [31:0] exp_rs2_data;
    logic        exp_rs2_busy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Each vector: apply the write side for one edge, then read on an idle cycle.
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  5,  32'h0,        0, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 0,  32'h0,        1, 7, 0, 7,  0,  32'h0,        1, 32'h0,        0};
    vecs[3]  = '{1, 7,  32'h12,       0, 0, 0, 7,  7,  32'h12,       0, 32'h12,       0};
    vecs[4]  = '{1, 9,  32'h99,       1, 9, 0, 9,  7,  32'h99,       1, 32'h12,       0};
    vecs[5]  = '{0, 0,  32'h0,        1, 3, 0, 3,  9,  32'h0,        1, 32'h99,       1};
    vecs[6]  = '{0, 0,  32'h0,        1, 4, 0, 4,  3,  32'h0,        1, 32'h0,        1};
    vecs[7]  = '{0, 0,  32'h0,        1, 5, 0, 5,  4,  32'hDEADBEEF, 1, 32'h0,        1};
    vecs[8]  = '{0, 0,  32'h0,        1, 4, 1, 3,  4,  32'h0,        0, 32'h0,        1};
    vecs[9]  = '{0, 0,  32'h0,        0, 0, 0, 5,  9,  32'hDEADBEEF, 0, 32'h99,       0};
    vecs[10] = '{1, 4,  32'h44,       0, 0, 0, 4,  5,  32'h44,       0, 32'hDEADBEEF, 0};
    vecs[11] = '{1, 31, 32'hCAFEF00D, 0, 0, 0, 31, 30, 32'hCAFEF00D, 0, 32'h0,        0};
  end

  initial begin
    int ops;
    logic [31:0] old10;

    idle();
    rst = 1; rs1_addr = 5; rs2_addr = 9;
    tick(); tick();
    rst = 0;
    #3;
    check("reset_rs1_data", rs1_data, 32'd0);
    check("reset_rs2_busy", {31'd0, rs2_busy}, 32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      wr_en = vecs[i].wr_en; rd_addr = vecs[i].rd_addr; rd_data = vecs[i].rd_data;
      sb_set = vecs[i].sb_set; sb_set_addr = vecs[i].sb_set_addr; sb_flush = vecs[i].sb_flush;
      rs1_addr = 0; rs2_addr = 0;
      tick();
      idle();
      rs1_addr = vecs[i].rs1_addr; rs2_addr = vecs[i].rs2_addr;
      #3;
      check($sformatf("vec%0d_rs1_data", i), rs1_data, vecs[i].exp_rs1_data);
      check($sformatf("vec%0d_rs1_busy", i), {31'd0, rs1_busy}, {31'd0, vecs[i].exp_rs1_busy});
      check($sformatf("vec%0d_rs2_data", i), rs2_data, vecs[i].exp_rs2_data);
      check($sformatf("vec%0d_rs2_busy", i), {31'd0, rs2_busy}, {31'd0, vecs[i].exp_rs2_busy});
      tick();
    end

    // Bypass corner: old value 0x11 pending on addr 10, then writeback while reading it.
    wr_en = 1; rd_addr = 10; rd_data = 32'h11; tick();
    idle(); sb_set = 1; sb_set_addr = 10; tick();
    idle();
    wr_en = 1; rd_addr = 10; rd_data = 32'hA5A5A5A5; rs1_addr = 10; rs2_addr = 10;
    #3;
    old10 = 32'h11;
`ifdef WRITE_BYPASS_EN
    check("bypass_same_cycle_data", rs1_data, 32'hA5A5A5A5);
    check("bypass_same_cycle_busy", {31'd0, rs1_busy}, 32'd0);
`else
    check("bypass_same_cycle_data", rs1_data, old10);
    check("bypass_same_cycle_busy", {31'd0, rs1_busy}, 32'd1);
`endif
    tick();
    idle();
    #3;
    check("bypass_next_cycle_data", rs2_data, 32'hA5A5A5A5);
    check("bypass_next_cycle_busy", {31'd0, rs2_busy}, 32'd0);
    tick();

    // Randomized traffic checked every cycle against the model, with dense address reuse.
    for (int c = 0; c < 400; c++) begin
      ops = $urandom_range(0, 3);
      wr_en = $urandom_range(0, 1);
      rd_addr = (ops == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rd_data = $urandom;
      sb_set = $urandom_range(0, 1);
      sb_set_addr = (ops == 1) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      sb_flush = ($urandom_range(0, 15) == 0);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = (ops == 2) ? rd_addr : 5'($urandom_range(0, 31));
      #3;
      check("rand_rs1_data", rs1_data, exp_data(rs1_addr));
      check("rand_rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
      check("rand_rs2_data", rs2_data, exp_data(rs2_addr));
      check("rand_rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
      tick();
    end

    // Reset mid-operation: the write and set in the reset cycle are lost.
    wr_en = 1; rd_addr = 6; rd_data = 32'h66; sb_set = 1; sb_set_addr = 6; rst = 1;
    tick();
    rst = 0; idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("post_reset_rs1_data_%0d", i), rs1_data, 32'd0);
      check($sformatf("post_reset_busy_%0d", i), {30'd0, rs1_busy, rs2_busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
